// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with architectural HI/LO registers
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             HiWE,
    input  logic             LoWE,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
    state_t state, state_nxt;

    logic [1:0]         op_r;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dividend;

    assign Busy = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sign_a   = Op[0] & OpA[WIDTH-1];
        sign_b   = Op[0] & OpB[WIDTH-1];
        a_abs    = sign_a ? -OpA : OpA;
        b_abs    = sign_b ? -OpB : OpB;
        // Multiply: add multiplier into the upper half, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
        // Divide: acc holds {remainder, remaining dividend bits / quotient bits}.
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {2'b00, b_mag};
        if (op_r[1])
            acc_nxt = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        prod     = neg_res ? -acc : acc;
        quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        // Reconstructs the raw dividend (the magnitude negation round-trips, including the most negative value).
        dividend = neg_rem ? -a_mag : a_mag;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_r    <= 2'b00;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_mag   <= '0;
            b_mag   <= '0;
            count   <= '0;
            acc     <= '0;
            HI      <= '0;
            LO      <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done    <= (state == FIXUP);
            DivZero <= (state == FIXUP) && op_r[1] && (b_mag == '0);
            case (state)
                IDLE: begin
                    if (HiWE) HI <= WrData;
                    if (LoWE) LO <= WrData;
                    if (Start) begin
                        op_r    <= Op;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        count   <= '0;
                        acc     <= {{WIDTH{1'b0}}, a_abs};
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    if (!op_r[1]) begin
                        HI <= prod[2*WIDTH-1:WIDTH];
                        LO <= prod[WIDTH-1:0];
                    end else if (b_mag == '0) begin
                        HI <= dividend;
                        LO <= '1;
                    end else begin
                        HI <= rem;
                        LO <= quo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
